// File: rtl/fib_ctrl_pkg.sv
// Shared types and select encodings for the recursive Fibonacci controller.
// The control word bundles every strobe and mux select driven to the datapath.
package fib_ctrl_pkg;

    localparam int WORD_W = 8;

    typedef enum logic [4:0] {
        S_IDLE = 5'd0,
        S_LOAD = 5'd1,
        S_CALL = 5'd2,
        S_DN1  = 5'd3,
        S_SF1  = 5'd4,
        S_RET  = 5'd5,
        S_A1   = 5'd6,
        S_A2   = 5'd7,
        S_A3   = 5'd8,
        S_A4   = 5'd9,
        S_A5   = 5'd10,
        S_A6   = 5'd11,
        S_B1   = 5'd12,
        S_B2   = 5'd13,
        S_B3   = 5'd14,
        S_B4   = 5'd15,
        S_FIN  = 5'd16,
        S_DONE = 5'd17
    } state_e;

    localparam logic       OP_ADD    = 1'b0;
    localparam logic       OP_SUB    = 1'b1;
    localparam logic       SEL_ALU   = 1'b0;
    localparam logic       SEL_STACK = 1'b1;
    localparam logic [1:0] RETS_ONE  = 2'd0;
    localparam logic [1:0] RETS_ALU  = 2'd1;
    localparam logic [1:0] ADDL_ZERO = 2'd0;
    localparam logic [1:0] ADDL_N    = 2'd1;
    localparam logic [1:0] ADDL_RES  = 2'd2;
    localparam logic [1:0] ADDR_F    = 2'd0;
    localparam logic [1:0] ADDR_RET  = 2'd1;
    localparam logic [1:0] ADDR_ONE  = 2'd2;
    localparam logic [1:0] ADDR_TWO  = 2'd3;
    localparam logic [1:0] SS_F      = 2'd0;
    localparam logic [1:0] SS_N      = 2'd1;
    localparam logic [1:0] SS_RES    = 2'd2;

    typedef struct packed {
        logic       push;
        logic       pop;
        logic       addsub;
        logic       ns;
        logic       fs;
        logic       ress;
        logic       nld;
        logic       fld;
        logic       resld;
        logic       retld;
        logic       nrst;
        logic       frst;
        logic       resrst;
        logic       retrst;
        logic [1:0] rets;
        logic [1:0] addls;
        logic [1:0] addrs;
        logic [1:0] ss;
    } ctrl_t;

    function automatic ctrl_t ctrl_none();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

    function automatic ctrl_t ctrl_clear_all();
        ctrl_t c;
        c        = '0;
        c.nrst   = 1'b1;
        c.frst   = 1'b1;
        c.resrst = 1'b1;
        c.retrst = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/fib_controller_if.sv
// Handshake and datapath-control bundle between the controller and its datapath.
interface fib_controller_if #(parameter int DW = fib_ctrl_pkg::WORD_W);
    logic          start;
    logic [DW-1:0] arg;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic          lt;
    logic          gt;
    logic          eq;
    logic [DW-1:0] n;
    logic [DW-1:0] f;
    logic          push, pop, addsub;
    logic          ns, fs, ress;
    logic          nld, fld, resld, retld;
    logic          nrst, frst, resrst, retrst;
    logic [1:0]    rets, addls, addrs, ss;

    modport master (
        input  start, arg, lt, gt, eq, n, f,
        output busy, done, result, push, pop, addsub, ns, fs, ress,
               nld, fld, resld, retld, nrst, frst, resrst, retrst,
               rets, addls, addrs, ss
    );

    modport slave (
        output start, arg, lt, gt, eq, n, f,
        input  busy, done, result, push, pop, addsub, ns, fs, ress,
               nld, fld, resld, retld, nrst, frst, resrst, retrst,
               rets, addls, addrs, ss
    );
endinterface

// File: rtl/fib_ctrl_decode.sv
// Combinational next-state and control-word map for the Fibonacci controller.
module fib_ctrl_decode import fib_ctrl_pkg::*; (
    input  state_e            state,
    input  logic [WORD_W-1:0] f,
    input  logic              gt,
    input  logic              start,
    input  logic              n_match,
    output ctrl_t             ctrl,
    output state_e            state_nxt
);

    // Next-state and strobe decode; everything unlisted stays zero
    always_comb begin
        ctrl      = ctrl_none();
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    ctrl      = ctrl_clear_all();
                    state_nxt = S_LOAD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                if (n_match) begin
                    state_nxt = S_CALL;
                end else begin
                    ctrl.nld    = 1'b1;
                    ctrl.ns     = SEL_ALU;
                    ctrl.addls  = ADDL_N;
                    ctrl.addrs  = ADDR_ONE;
                    ctrl.addsub = OP_ADD;
                    state_nxt   = S_LOAD;
                end
            end
            S_CALL: begin
                if (!gt) begin
                    ctrl.rets  = RETS_ONE;
                    ctrl.retld = 1'b1;
                    state_nxt  = S_RET;
                end else begin
                    ctrl.push = 1'b1;
                    ctrl.ss   = SS_F;
                    state_nxt = S_DN1;
                end
            end
            S_DN1: begin
                ctrl.push   = 1'b1;
                ctrl.ss     = SS_N;
                ctrl.addls  = ADDL_N;
                ctrl.addrs  = ADDR_ONE;
                ctrl.addsub = OP_SUB;
                ctrl.nld    = 1'b1;
                ctrl.frst   = 1'b1;
                state_nxt   = S_SF1;
            end
            S_SF1: begin
                ctrl.fld  = 1'b1;
                ctrl.fs   = SEL_ALU;
                state_nxt = S_CALL;
            end
            // f records which recursive call is returning
            S_RET: begin
                if (f == 8'd0) begin
                    state_nxt = S_FIN;
                end else if (f == 8'd1) begin
                    state_nxt = S_A1;
                end else if (f == 8'd2) begin
                    state_nxt = S_B1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_A1: begin
                ctrl.pop  = 1'b1;
                ctrl.ns   = SEL_STACK;
                ctrl.nld  = 1'b1;
                state_nxt = S_A2;
            end
            S_A2: begin
                ctrl.addls = ADDL_ZERO;
                ctrl.addrs = ADDR_RET;
                ctrl.ress  = SEL_ALU;
                ctrl.resld = 1'b1;
                state_nxt  = S_A3;
            end
            S_A3: begin
                ctrl.push   = 1'b1;
                ctrl.ss     = SS_N;
                ctrl.addls  = ADDL_N;
                ctrl.addrs  = ADDR_TWO;
                ctrl.addsub = OP_SUB;
                ctrl.nld    = 1'b1;
                state_nxt   = S_A4;
            end
            S_A4: begin
                ctrl.push = 1'b1;
                ctrl.ss   = SS_RES;
                ctrl.frst = 1'b1;
                state_nxt = S_A5;
            end
            S_A5: begin
                ctrl.fld  = 1'b1;
                ctrl.fs   = SEL_ALU;
                state_nxt = S_A6;
            end
            S_A6: begin
                ctrl.fld  = 1'b1;
                ctrl.fs   = SEL_ALU;
                state_nxt = S_CALL;
            end
            S_B1: begin
                ctrl.pop   = 1'b1;
                ctrl.ress  = SEL_STACK;
                ctrl.resld = 1'b1;
                state_nxt  = S_B2;
            end
            S_B2: begin
                ctrl.addls  = ADDL_RES;
                ctrl.addrs  = ADDR_RET;
                ctrl.addsub = OP_ADD;
                ctrl.rets   = RETS_ALU;
                ctrl.retld  = 1'b1;
                state_nxt   = S_B3;
            end
            S_B3: begin
                ctrl.pop  = 1'b1;
                state_nxt = S_B4;
            end
            S_B4: begin
                ctrl.pop  = 1'b1;
                ctrl.fs   = SEL_STACK;
                ctrl.fld  = 1'b1;
                state_nxt = S_RET;
            end
            S_FIN: begin
                ctrl.addls = ADDL_ZERO;
                ctrl.addrs = ADDR_RET;
                ctrl.ns    = SEL_ALU;
                ctrl.nld   = 1'b1;
                state_nxt  = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/fib_controller.sv
// Recursive Fibonacci controller: state register, argument and result latches,
// driving an external datapath (n/f/res/ret registers, ALU and stack).
module fib_controller import fib_ctrl_pkg::*; #(
    parameter int DW = WORD_W
) (
    input logic               clk,
    input logic               rst,
    fib_controller_if.master  bus
);

    state_e        state_r;
    state_e        state_nxt_s;
    ctrl_t         dec_s;
    ctrl_t         ctrl_s;
    logic [DW-1:0] arg_q_r;
    logic [DW-1:0] result_r;
    logic          greater_s;
    logic          n_match_s;

    // Recurse only when the comparator reports strictly greater than two
    assign greater_s = bus.gt & ~bus.lt & ~bus.eq;
    assign n_match_s = (bus.n == arg_q_r);

    fib_ctrl_decode u_decode (
        .state     (state_r),
        .f         (bus.f),
        .gt        (greater_s),
        .start     (bus.start),
        .n_match   (n_match_s),
        .ctrl      (dec_s),
        .state_nxt (state_nxt_s)
    );

    // Reset holds the datapath registers cleared whatever state we were in
    always_comb begin
        ctrl_s = dec_s;
        if (rst) begin
            ctrl_s = ctrl_clear_all();
        end else begin
            ctrl_s = dec_s;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Argument latch, captured only when a request is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            arg_q_r <= '0;
        end else if ((state_r == S_IDLE) && bus.start) begin
            arg_q_r <= bus.arg;
        end
    end

    // Result latch, holds until the next completed run
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= '0;
        end else if (state_r == S_DONE) begin
            result_r <= bus.n;
        end
    end

    assign bus.busy   = ~rst & (state_r != S_IDLE);
    assign bus.done   = ~rst & (state_r == S_DONE);
    assign bus.result = result_r;
    assign bus.push   = ctrl_s.push;
    assign bus.pop    = ctrl_s.pop;
    assign bus.addsub = ctrl_s.addsub;
    assign bus.ns     = ctrl_s.ns;
    assign bus.fs     = ctrl_s.fs;
    assign bus.ress   = ctrl_s.ress;
    assign bus.nld    = ctrl_s.nld;
    assign bus.fld    = ctrl_s.fld;
    assign bus.resld  = ctrl_s.resld;
    assign bus.retld  = ctrl_s.retld;
    assign bus.nrst   = ctrl_s.nrst;
    assign bus.frst   = ctrl_s.frst;
    assign bus.resrst = ctrl_s.resrst;
    assign bus.retrst = ctrl_s.retrst;
    assign bus.rets   = ctrl_s.rets;
    assign bus.addls  = ctrl_s.addls;
    assign bus.addrs  = ctrl_s.addrs;
    assign bus.ss     = ctrl_s.ss;

endmodule

// File: tb/tb_fib_controller.sv
// Bench for fib_controller: a behavioural datapath (registers, ALU, stack)
// closes the loop, and results are checked against hand-computed Fibonacci values.
module tb_fib_controller;

    localparam int LIMIT = 20000;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fib_controller_if #(.DW(8)) bus ();
    fib_controller #(.DW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] m_n = 8'd0, m_f = 8'd0, m_res = 8'd0, m_ret = 8'd0;
    logic [7:0] stk [0:DEPTH-1];
    int sp = 0;
    int push_total = 0, pop_total = 0, done_total = 0, both_err = 0, stack_err = 0;
    logic [7:0] alu_l, alu_r, alu_o, dout, push_val;

    assign dout  = (sp > 0) ? stk[sp-1] : 8'd0;
    assign bus.n  = m_n;
    assign bus.f  = m_f;
    assign bus.lt = (m_n < 8'd2);
    assign bus.eq = (m_n == 8'd2);
    assign bus.gt = (m_n > 8'd2);

    always_comb begin
        case (bus.addls)
            2'd1:    alu_l = m_n;
            2'd2:    alu_l = m_res;
            default: alu_l = 8'd0;
        endcase
        case (bus.addrs)
            2'd0:    alu_r = m_f;
            2'd1:    alu_r = m_ret;
            2'd2:    alu_r = 8'd1;
            default: alu_r = 8'd2;
        endcase
        alu_o = bus.addsub ? (alu_l - alu_r) : (alu_l + alu_r);
        case (bus.ss)
            2'd0:    push_val = m_f;
            2'd1:    push_val = m_n;
            default: push_val = m_res;
        endcase
    end

    always @(posedge clk) begin
        if (bus.nrst) m_n <= 8'd0;
        else if (bus.nld) m_n <= bus.ns ? dout : alu_o;
        if (bus.frst) m_f <= 8'd0;
        else if (bus.fld) m_f <= bus.fs ? dout : (m_f + 8'd1);
        if (bus.resrst) m_res <= 8'd0;
        else if (bus.resld) m_res <= bus.ress ? dout : alu_o;
        if (bus.retrst) m_ret <= 8'd0;
        else if (bus.retld) m_ret <= (bus.rets == 2'd1) ? alu_o : 8'd1;
        if (bus.push && bus.pop) both_err <= both_err + 1;
        if (bus.push) begin
            if (sp < DEPTH) begin
                stk[sp] <= push_val;
                sp <= sp + 1;
            end else begin
                stack_err <= stack_err + 1;
            end
            push_total <= push_total + 1;
        end else if (bus.pop) begin
            if (sp > 0) sp <= sp - 1;
            else stack_err <= stack_err + 1;
            pop_total <= pop_total + 1;
        end
        if (bus.done) done_total <= done_total + 1;
    end

    int tests = 0;
    int failed = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Launch one request, optionally poking start again while busy, and wait for done
    task automatic run_calc(input logic [7:0] a, input int poke_at, input logic [7:0] poke_arg,
                            output int cyc, output int dones, output int pushes, output int pops,
                            output logic [7:0] res_o, output logic seen, output logic done_after);
        int d0, p0, q0;
        @(negedge clk);
        d0 = done_total; p0 = push_total; q0 = pop_total;
        bus.arg = a;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        seen = 1'b0;
        while (!seen && cyc < LIMIT) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (cyc == poke_at) begin
                    bus.start = 1'b1;
                    bus.arg = poke_arg;
                end else begin
                    bus.start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
        res_o = bus.result;
        done_after = bus.done;
        pushes = push_total - p0;
        pops = pop_total - q0;
        dones = done_total - d0;
    endtask

    typedef struct {
        logic [7:0] arg;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [10];
    int cyc, dones, pushes, pops, d0;
    logic [7:0] res;
    logic seen, done_after;

    initial begin
        vecs[0] = '{8'd0, 8'd1};
        vecs[1] = '{8'd1, 8'd1};
        vecs[2] = '{8'd2, 8'd1};
        vecs[3] = '{8'd3, 8'd2};
        vecs[4] = '{8'd4, 8'd3};
        vecs[5] = '{8'd5, 8'd5};
        vecs[6] = '{8'd6, 8'd8};
        vecs[7] = '{8'd7, 8'd13};
        vecs[8] = '{8'd10, 8'd55};
        vecs[9] = '{8'd13, 8'd233};

        bus.start = 1'b0;
        bus.arg = 8'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_result", int'(bus.result), 0);
        check("rst_clears", int'({bus.nrst, bus.frst, bus.resrst, bus.retrst}), 15);
        check("rst_other_strobes", int'({bus.push, bus.pop, bus.nld, bus.fld, bus.resld, bus.retld}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_strobes", int'({bus.nrst, bus.frst, bus.push, bus.pop, bus.nld, bus.fld}), 0);
        check("idle_busy", int'(bus.busy), 0);

        for (int i = 0; i < 10; i++) begin
            run_calc(vecs[i].arg, -1, 8'd0, cyc, dones, pushes, pops, res, seen, done_after);
            check($sformatf("done_seen_arg%0d", vecs[i].arg), int'(seen), 1);
            check($sformatf("result_arg%0d", vecs[i].arg), int'(res), int'(vecs[i].exp));
            check($sformatf("done_pulses_arg%0d", vecs[i].arg), dones, 1);
            check($sformatf("done_low_after_arg%0d", vecs[i].arg), int'(done_after), 0);
            check($sformatf("push_pop_balance_arg%0d", vecs[i].arg), pushes - pops, 0);
            if (vecs[i].arg == 8'd0) check("arg0_latency_le5", int'(cyc <= 5), 1);
            if (vecs[i].arg == 8'd2) check("arg2_no_push", pushes, 0);
            if (vecs[i].arg == 8'd6) check("arg6_pushes_nonzero", int'(pushes > 0), 1);
        end

        // Abort a long run with reset, then confirm a clean restart
        @(negedge clk);
        bus.arg = 8'd10;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_busy_before", int'(bus.busy), 1);
        d0 = done_total;
        rst = 1'b1;
        #1;
        check("abort_rst_clears", int'({bus.nrst, bus.frst, bus.resrst, bus.retrst}), 15);
        check("abort_rst_no_stack", int'({bus.push, bus.pop, bus.nld, bus.fld}), 0);
        check("abort_rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_idle_next", int'(bus.busy), 0);
        repeat (20) @(negedge clk);
        check("abort_no_done", done_total - d0, 0);
        check("abort_stays_idle", int'(bus.busy), 0);
        run_calc(8'd6, -1, 8'd0, cyc, dones, pushes, pops, res, seen, done_after);
        check("after_abort_result", int'(res), 8);
        check("after_abort_done_pulses", dones, 1);

        // A second start while busy must be ignored
        run_calc(8'd5, 3, 8'd9, cyc, dones, pushes, pops, res, seen, done_after);
        check("busy_start_result", int'(res), 5);
        check("busy_start_done_pulses", dones, 1);
        repeat (5) @(negedge clk);
        check("busy_start_no_rerun", int'(bus.busy), 0);
        check("result_holds", int'(bus.result), 5);

        check("push_pop_exclusive", both_err, 0);
        check("stack_in_range", stack_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
